spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl_if.sv | 41 ++++
 rtl/spi_xfer_ctrl.sv | 103 ++++++++++
 tb/tb_spi_xfer_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if -- register/clock-generator side signals of the SPI transfer controller.
//
// master modport (register block / clock generator side) drives:
//   go, char_len, tx_negedge, rx_negedge, ass, ss_mask, pos_edge, neg_edge, abort
// slave modport (spi_xfer_ctrl) drives:
//   tip, last_clk, tx_shift, rx_sample, bit_cnt, done, aborted, ss_pad_o
//
// The parameters must match those of the spi_xfer_ctrl instance the interface is bound to.
interface spi_xfer_ctrl_if #(
  parameter int unsigned SS_NB         = 8,
  parameter int unsigned CHAR_LEN_BITS = 7
);
  logic                     go;
  logic [CHAR_LEN_BITS-1:0] char_len;
  logic                     tx_negedge;
  logic                     rx_negedge;
  logic                     ass;
  logic [SS_NB-1:0]         ss_mask;
  logic                     pos_edge;
  logic                     neg_edge;
  logic                     abort;

  logic                     tip;
  logic                     last_clk;
  logic                     tx_shift;
  logic                     rx_sample;
  logic [CHAR_LEN_BITS:0]   bit_cnt;
  logic                     done;
  logic                     aborted;
  logic [SS_NB-1:0]         ss_pad_o;

  modport master (
    output go, char_len, tx_negedge, rx_negedge, ass, ss_mask, pos_edge, neg_edge, abort,
    input  tip, last_clk, tx_shift, rx_sample, bit_cnt, done, aborted, ss_pad_o
  );

  modport slave (
    input  go, char_len, tx_negedge, rx_negedge, ass, ss_mask, pos_edge, neg_edge, abort,
    output tip, last_clk, tx_shift, rx_sample, bit_cnt, done, aborted, ss_pad_o
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl -- SPI transfer sequencer.
//
// Counts the bits of one SPI character, turns the clock generator's pos_edge/neg_edge strobes
// into shift/sample strobes, and drives the registered active-low slave selects.
//
// Ports:
//   wb_clk_in  system clock, all state updates on its rising edge
//   wb_rst     asynchronous active-high reset
//   bus        spi_xfer_ctrl_if.slave:
//     in : go, char_len (0 = 2^CHAR_LEN_BITS bits), tx_negedge, rx_negedge, ass, ss_mask,
//          pos_edge, neg_edge, abort
//     out: tip, last_clk, tx_shift, rx_sample, bit_cnt (bits remaining), done, aborted,
//          ss_pad_o
module spi_xfer_ctrl #(
  parameter int unsigned SS_NB         = 8,
  parameter int unsigned CHAR_LEN_BITS = 7
) (
  input logic            wb_clk_in,
  input logic            wb_rst,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StTail, StDone} state_e;

  localparam logic [CHAR_LEN_BITS:0] CntOne = {{CHAR_LEN_BITS{1'b0}}, 1'b1};
  localparam logic [CHAR_LEN_BITS:0] CntMax = {1'b1, {CHAR_LEN_BITS{1'b0}}};

  state_e                 state_q, state_d;
  logic [CHAR_LEN_BITS:0] bit_cnt_q, bit_cnt_d;
  logic                   aborted_q, aborted_d;
  logic [SS_NB-1:0]       ss_q, ss_d;
  logic                   tip, tip_d;
  logic                   tx_shift, rx_sample;

  assign tip       = (state_q == StXfer) || (state_q == StTail);
  assign tx_shift  = tip & (bus.tx_negedge ? bus.neg_edge : bus.pos_edge);
  assign rx_sample = tip & (bus.rx_negedge ? bus.neg_edge : bus.pos_edge);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d   = StXfer;
          bit_cnt_d = (bus.char_len == '0) ? CntMax : {1'b0, bus.char_len};
        end
      end
      StXfer: begin
        // abort outranks a coincident final sample
        if (bus.abort) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (rx_sample) begin
          if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - CntOne;
          // a rising-edge final sample still owes the trailing falling edge of sclk
          if (bit_cnt_q == CntOne) state_d = bus.rx_negedge ? StDone : StTail;
        end
      end
      StTail: begin
        if (bus.abort) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (bus.neg_edge) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // selects are registered from next-state tip so they track tip edge-for-edge
    tip_d = (state_d == StXfer) || (state_d == StTail);
    ss_d  = ~(bus.ss_mask & (bus.ass ? {SS_NB{tip_d}} : {SS_NB{1'b1}}));
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      aborted_q <= 1'b0;
      ss_q      <= {SS_NB{1'b1}};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      aborted_q <= aborted_d;
      ss_q      <= ss_d;
    end
  end

  assign bus.tip       = tip;
  assign bus.last_clk  = tip & (bit_cnt_q <= CntOne);
  assign bus.tx_shift  = tx_shift;
  assign bus.rx_sample = rx_sample;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.done      = (state_q == StDone);
  assign bus.aborted   = aborted_q;
  assign bus.ss_pad_o  = ss_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl -- self-checking bench for spi_xfer_ctrl.
// A fixed vector table, directed corner-case sequences and a randomized run compared every
// cycle against a transaction-level model (bits left to sample, then an optional wait for
// the trailing falling edge).
module tb_spi_xfer_ctrl;
  localparam int unsigned SS_NB   = 8;
  localparam int unsigned CLB     = 7;
  localparam int          MaxBits = 128;

  logic wb_clk_in = 1'b0;
  logic wb_rst    = 1'b0;

  spi_xfer_ctrl_if #(.SS_NB(SS_NB), .CHAR_LEN_BITS(CLB)) bus ();

  spi_xfer_ctrl #(.SS_NB(SS_NB), .CHAR_LEN_BITS(CLB)) dut (
    .wb_clk_in(wb_clk_in),
    .wb_rst   (wb_rst),
    .bus      (bus.slave)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         m_busy, m_wait_fall, m_done, m_abt;
  int         m_left;
  logic [7:0] m_ss;

  typedef struct {
    logic        go, pe, ne, ab;
    logic [31:0] exp;
  } vec_t;

  // {10'b0, tip, last_clk, tx_shift, rx_sample, done, aborted, bit_cnt[7:0], ss_pad_o[7:0]}
  function automatic logic [31:0] mk(input logic t, l, x, r, d, a, input logic [7:0] c, s);
    return {10'b0, t, l, x, r, d, a, c, s};
  endfunction

  function automatic logic [31:0] pack_dut();
    return mk(bus.tip, bus.last_clk, bus.tx_shift, bus.rx_sample, bus.done, bus.aborted,
              bus.bit_cnt, bus.ss_pad_o);
  endfunction

  function automatic logic [31:0] pack_model(input logic pe, ne);
    logic txs, rxs, lc;
    txs = m_busy && (bus.tx_negedge ? ne : pe);
    rxs = m_busy && (bus.rx_negedge ? ne : pe);
    lc  = m_busy && (m_left <= 1);
    return mk(m_busy, lc, txs, rxs, m_done, m_abt, 8'(m_left), m_ss);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait_fall = 0; m_done = 0; m_abt = 0; m_left = 0; m_ss = 8'hFF;
  endtask

  // one clock of the transfer: a character is char_len samples, then (for a rising-edge
  // final sample) one more falling edge, then a single done cycle
  task automatic model_next(input logic g, pe, ne, ab);
    bit idle, rxs;
    idle   = !m_busy && !m_done;
    rxs    = m_busy && (bus.rx_negedge ? ne : pe);
    m_done = 0;
    m_abt  = 0;
    if (idle) begin
      if (g) begin
        m_busy      = 1;
        m_wait_fall = 0;
        m_left      = (bus.char_len == 0) ? MaxBits : int'(bus.char_len);
      end
    end else if (m_busy) begin
      if (ab) begin
        m_busy = 0; m_left = 0; m_abt = 1;
      end else if (m_wait_fall) begin
        if (ne) begin m_busy = 0; m_done = 1; end
      end else if (rxs) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (bus.rx_negedge) begin m_busy = 0; m_done = 1; end
          else m_wait_fall = 1;
        end
      end
    end
    m_ss = ~(bus.ss_mask & (bus.ass ? {8{m_busy}} : 8'hFF));
  endtask

  // entered at posedge+1, returns at the following posedge+1
  task automatic cycle(input string name, input logic g, pe, ne, ab, output logic [31:0] seen);
    bus.go = g; bus.pos_edge = pe; bus.neg_edge = ne; bus.abort = ab;
    #1;
    seen = pack_dut();
    check(name, seen, pack_model(pe, ne));
    model_next(g, pe, ne, ab);
    @(posedge wb_clk_in);
    #1;
  endtask

  task automatic tick(input string name, input logic g, pe, ne, ab);
    logic [31:0] s;
    cycle(name, g, pe, ne, ab, s);
  endtask

  task automatic set_cfg(input int cl, input logic txn, rxn, a, input logic [7:0] mask);
    bus.char_len = 7'(cl); bus.tx_negedge = txn; bus.rx_negedge = rxn;
    bus.ass = a; bus.ss_mask = mask;
  endtask

  task automatic pulse_reset();
    wb_rst = 1'b1;
    #1;
    wb_rst = 1'b0;
    model_reset();
  endtask

  // alternating pos/neg strobes (pos first) until done, bounded by max_cycles
  task automatic run_xfer(input string name, input int max_cycles,
                          output int nsamp, output bit got_done, output logic [31:0] at_done);
    logic [31:0] s;
    nsamp = 0; got_done = 0; at_done = '0;
    for (int c = 0; c < max_cycles && !got_done; c++) begin
      cycle(name, 1'b0, (c % 2) == 0, (c % 2) == 1, 1'b0, s);
      if (s[18] && s[15:8] != 8'd0) nsamp++;
      if (s[17]) begin got_done = 1; at_done = s; end
    end
  endtask

  initial begin
    vec_t        vecs[12];
    int          nsamp;
    bit          got_done;
    logic [31:0] at_done;
    logic [31:0] s;

    // char_len=2, drive on fall, sample on rise, auto-select on slaves 0 and 2
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF)};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 0, 8'd2, 8'hFA)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 8'd1, 8'hFA)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 1, 0, 0, 8'd1, 8'hFA)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 1, 0, 0, 8'd0, 8'hFA)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 8'd0, 8'hFA)};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 8'd0, 8'hFF)};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 8'd2, 8'hFA)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 8'd0, 8'hFF)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF)};

    bus.go = 0; bus.pos_edge = 0; bus.neg_edge = 0; bus.abort = 0;
    set_cfg(2, 1'b1, 1'b0, 1'b1, 8'h05);
    model_reset();

    // reset takes effect with no clock edge
    #1 wb_rst = 1'b1;
    #1 check("reset_state", pack_dut(), mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF));
    @(posedge wb_clk_in);
    #1 wb_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.go = vecs[i].go; bus.pos_edge = vecs[i].pe;
      bus.neg_edge = vecs[i].ne; bus.abort = vecs[i].ab;
      #1;
      check($sformatf("vec%0d", i), pack_dut(), vecs[i].exp);
      @(posedge wb_clk_in);
      #1;
    end
    pulse_reset();

    // 8-bit transfer, sample on rise, single slave
    set_cfg(8, 1'b1, 1'b0, 1'b1, 8'h01);
    tick("x8_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("x8_go", 1'b1, 1'b0, 1'b0, 1'b0);
    check("x8_start", {bus.tip, 23'b0, bus.ss_pad_o}, {1'b1, 23'b0, 8'hFE});
    run_xfer("x8", 40, nsamp, got_done, at_done);
    check("x8_done_seen", 32'(got_done), 32'd1);
    check("x8_samples", nsamp, 32'd8);
    check("x8_end_state", {at_done[21], 23'b0, at_done[7:0]}, {1'b0, 23'b0, 8'hFF});

    // char_len=0 is the maximum length
    set_cfg(0, 1'b1, 1'b0, 1'b1, 8'h80);
    tick("x128_go", 1'b1, 1'b0, 1'b0, 1'b0);
    check("x128_load", 32'(bus.bit_cnt), 32'd128);
    run_xfer("x128", 400, nsamp, got_done, at_done);
    check("x128_done_seen", 32'(got_done), 32'd1);
    check("x128_samples", nsamp, 32'd128);

    // single bit sampled on fall goes straight to done
    set_cfg(1, 1'b0, 1'b1, 1'b1, 8'h02);
    tick("x1_go", 1'b1, 1'b0, 1'b0, 1'b0);
    check("x1_last_clk", {31'b0, bus.last_clk}, 32'd1);
    tick("x1_fall", 1'b0, 1'b0, 1'b1, 1'b0);
    check("x1_done", {30'b0, bus.tip, bus.done}, 32'd1);
    tick("x1_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort at bit_cnt=3 together with a sample strobe, then a fresh transfer
    set_cfg(5, 1'b1, 1'b0, 1'b1, 8'h10);
    tick("ab_go", 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ab_s1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("ab_f1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick("ab_s2", 1'b0, 1'b1, 1'b0, 1'b0);
    check("ab_cnt3", 32'(bus.bit_cnt), 32'd3);
    tick("ab_hit", 1'b0, 1'b1, 1'b0, 1'b1);
    check("ab_result", pack_dut(), mk(0, 0, 0, 0, 0, 1, 8'd0, 8'hFF));
    for (int i = 0; i < 3; i++) tick("ab_quiet", 1'b0, 1'b1, 1'b1, 1'b0);
    tick("ab_rego", 1'b1, 1'b0, 1'b0, 1'b0);
    check("ab_fresh", 32'(bus.bit_cnt), 32'd5);

    // go held mid-transfer, then asynchronous reset between edges
    for (int i = 0; i < 4; i++) tick("hold_go", 1'b1, (i % 2) == 0, (i % 2) == 1, 1'b0);
    check("hold_go_cnt", 32'(bus.bit_cnt), 32'd3);
    bus.go = 1'b1; bus.pos_edge = 1'b1; wb_rst = 1'b1;
    #2 check("async_rst", pack_dut(), mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF));
    @(posedge wb_clk_in);
    #1 check("rst_go_drop", pack_dut(), mk(0, 0, 0, 0, 0, 0, 8'd0, 8'hFF));
    wb_rst = 1'b0;
    model_reset();
    tick("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized run against the model
    for (int c = 0; c < 2000; c++) begin
      int r;
      if (!m_busy && !m_done)
        set_cfg(($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 10)),
                1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      r = int'($urandom_range(0, 2));
      cycle("rand", 1'($urandom_range(0, 2) == 0), r == 1, r == 2,
            $urandom_range(0, 39) == 0, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
